uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: SAMPLES_PER_BIT, 16, number of sampleTick pulses per serial bit (>=2).
REQ-002 SHALL have parameter: DATA_BITS, 8, payload width (5..8).
REQ-003 SHALL have parameter: PARITY_EN, 0, 1 inserts an even-parity bit between data and stop.
REQ-004 SHALL use a single clock and an asynchronous, active-high reset, named as the codebase names them.
REQ-005 SHALL have port: clk  input  1  rising-edge clock.
REQ-006 SHALL have port: rst  input  1  asynchronous reset, active high.
REQ-007 SHALL have port: sampleTick  input  1  one-clk-wide enable at SAMPLES_PER_BIT x baud, the same tick used by the receive side.
REQ-008 SHALL have port: txStart  input  1  load request; level-sampled on clk.
REQ-009 SHALL have port: txData  input  DATA_BITS  payload, captured on acceptance.
REQ-010 SHALL have port: txOut  output  1  serial line, registered, idle high.
REQ-011 SHALL have port: txBusy  output  1  high from acceptance until frame end.
REQ-012 SHALL have port: txDone  output  1  one-clk pulse at frame end.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is entered only when PARITY_EN=1.
REQ-014 In IDLE, with txStart=1 at a clk edge, SHALL capture txData into a shift register, compute even parity (XOR of txData), enter START, clear tick counter and bit index, and drive txOut=0 and txBusy=1 from that edge.
REQ-015 Acceptance SHALL NOT depend on sampleTick; START begins counting from the first sampleTick after acceptance.
REQ-016 Tick counter SHALL increment only on sampleTick; each bit SHALL last exactly SAMPLES_PER_BIT sampleTick pulses; on sampleTick with counter=SAMPLES_PER_BIT-1, counter SHALL wrap to 0 and the bit/state SHALL advance on that edge.
REQ-017 With sampleTick=0, state, counter, bit index and txOut SHALL hold.
REQ-018 START SHALL drive txOut=0 for one bit time.
REQ-019 DATA SHALL drive DATA_BITS bits LSB first, txOut=shift[0], shifting right at each bit boundary; after bit index DATA_BITS-1 go to PARITY (PARITY_EN=1) or STOP.
REQ-020 PARITY SHALL drive the even-parity bit for one bit time.
REQ-021 STOP SHALL drive txOut=1 for one bit time; at its end SHALL enter IDLE, clear txBusy, and pulse txDone for exactly one clk.
REQ-022 txStart while txBusy=1 (including the txDone cycle) SHALL be ignored; txData changes after acceptance SHALL not affect the frame.
REQ-023 A held txStart SHALL be accepted on the first clk edge after txDone, giving back-to-back frames with one idle clk between stop and next start.
REQ-024 With sampleTick continuously high, a frame SHALL occupy (2+DATA_BITS+PARITY_EN) x SAMPLES_PER_BIT clks from acceptance edge to txDone edge.
REQ-025 Counter width SHALL be clog2(SAMPLES_PER_BIT); bit index width SHALL be clog2(DATA_BITS+1); no counter SHALL exceed its terminal value.

Reset
REQ-026 rst=1 SHALL immediately, without a clk edge, force IDLE, counter=0, bit index=0, shift register=0, txOut=1, txBusy=0, txDone=0.
REQ-027 rst asserted mid-frame SHALL abandon the frame with no txDone; after release the block SHALL accept only a new txStart.
REQ-028 txStart high during rst SHALL be ignored; if still high at the first clk edge after release it SHALL be accepted.

Verification
REQ-029 Idle: after reset, no txStart for 50 clks -> txOut=1, txBusy=0, txDone=0 throughout.
REQ-030 Basic frame: sampleTick=1 always, txData=8'hA5, 1-clk txStart -> txOut sequence 0,1,0,1,0,0,1,0,1,1, each held 16 clks; txDone pulses 160 clks after acceptance.
REQ-031 Tick gating: sampleTick every 4th clk, txData=8'h0F -> each bit held 64 clks; frame 640 clks; no shift when sampleTick=0.
REQ-032 Parity/back-to-back: PARITY_EN=1, txStart held, txData=8'h07 then 8'h03 -> parity bits 1 then 0; 176-clk frames; exactly one idle clk between frames; exactly one txDone per frame.
REQ-033 Busy rejection: txStart pulse with txData=8'hFF during DATA of an 8'h00 frame -> frame unchanged, single txDone.
REQ-034 Reset mid-frame: assert rst during bit 3 of an 8'h55 frame, between clk edges -> txOut=1 and txBusy=0 before next edge; no txDone; next txStart sends a full correct frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter paced by the oversampling tick shared with the receiver.
// Frame: start bit, DATA_BITS data bits LSB first, optional even parity, one stop bit.
module uart_tx #(
    parameter int SAMPLES_PER_BIT = 16,
    parameter int DATA_BITS       = 8,
    parameter bit PARITY_EN       = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sampleTick,
    input  logic                 txStart,
    input  logic [DATA_BITS-1:0] txData,
    output logic                 txOut,
    output logic                 txBusy,
    output logic                 txDone
);
    localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [IDX_W-1:0]     idx_q,    idx_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_out_q, tx_out_d;
    logic                 done_q,   done_d;
    logic                 bit_end;

    // A bit ends on the tick that completes its SAMPLES_PER_BIT-th count.
    assign bit_end = sampleTick && (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no branch can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_out_d = tx_out_q;
        done_d   = 1'b0;

        if (state_q != IDLE && sampleTick) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (txStart) begin
                    state_d  = START;
                    cnt_d    = '0;
                    idx_d    = '0;
                    shift_d  = txData;
                    parity_d = ^txData;
                    tx_out_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d  = DATA;
                    tx_out_d = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (PARITY_EN) begin
                            state_d  = PARITY;
                            tx_out_d = parity_q;
                        end else begin
                            state_d  = STOP;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        tx_out_d = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d  = STOP;
                    tx_out_d = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d  = IDLE;
                    tx_out_d = 1'b1;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                tx_out_d = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state updates use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_out_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_out_q <= tx_out_d;
            done_q   <= done_d;
        end
    end

    assign txOut  = tx_out_q;
    assign txBusy = (state_q != IDLE);
    assign txDone = done_q;
endmodule
